// File: rtl/calc_pkg.sv
// calc_pkg: key codes, FSM/op encodings and BCD digit type for the serial BCD calculator.
package calc_pkg;
    typedef logic [3:0] bcd_t;
    localparam bcd_t K_ADD = 4'hA;
    localparam bcd_t K_SUB = 4'hB;
    localparam bcd_t K_CLR = 4'hC;
    localparam bcd_t K_EQ  = 4'hD;
    typedef enum logic [2:0] {ENTRY_A, ENTRY_B, CALC, NEG, SHOW} state_t;
    typedef enum logic {ADD, SUB} op_t;
    function automatic bcd_t nines(input bcd_t d);
        return 4'd9 - d;
    endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one-digit BCD adder a+b+cin with decimal correction.
module bcd_digit_add
    import calc_pkg::*;
(
    input  bcd_t a_i,
    input  bcd_t b_i,
    input  logic cin_i,
    output bcd_t sum_o,
    output logic cout_o
);
    logic [4:0] s;
    assign s      = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
    assign cout_o = s > 5'd9;
    assign sum_o  = cout_o ? 4'(s - 5'd10) : s[3:0];
endmodule

// File: rtl/calc_bcd_serie.sv
// calc_bcd_serie: NDIG-digit BCD add/subtract calculator core, one digit per clock,
// sign+magnitude results via a ten's-complement pass and overflow flag.
module calc_bcd_serie
    import calc_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter bit WRAP_OVF = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [3:0]      key_code,
    output logic            key_ack,
    output logic            busy,
    output logic            done,
    output logic [4*NDIG-1:0] disp_bcd,
    output logic            disp_neg,
    output logic            ovf
);
    localparam int W  = 4 * NDIG;
    localparam int IW = $clog2(NDIG);
    localparam int CW = $clog2(NDIG + 1);

    state_t state_q, state_d;
    op_t op_q, op_d;
    logic [W-1:0] cur_q, cur_d, opa_q, opa_d, opb_q, opb_d;
    logic [W-1:0] work_q, work_d, res_q, res_d, work_upd, cur_nines;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, ovf_q, ovf_d, neg_q, neg_d;
    logic ack_q, ack_d, done_q, done_d;
    bcd_t add_a, add_b, add_sum;
    logic add_cout, last;

    // NEG reuses the CALC adder: (9 - r) + 0 + carry gives the ten's complement digit-serially
    assign add_a = (state_q == NEG) ? nines(work_q[{idx_q, 2'b00} +: 4]) : opa_q[{idx_q, 2'b00} +: 4];
    assign add_b = (state_q == NEG) ? 4'd0 : opb_q[{idx_q, 2'b00} +: 4];
    assign last  = idx_q == IW'(NDIG - 1);

    bcd_digit_add u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (carry_q),
        .sum_o (add_sum),
        .cout_o(add_cout)
    );

    always_comb begin
        work_upd = work_q;
        work_upd[{idx_q, 2'b00} +: 4] = add_sum;
        for (int i = 0; i < NDIG; i++) cur_nines[4*i +: 4] = nines(cur_q[4*i +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ENTRY_A;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        if (state_q == CALC || state_q == NEG) begin
            work_d  = work_upd;
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (last && state_q == NEG) begin
                res_d   = work_upd;
                neg_d   = 1'b1;
                state_d = SHOW;
                done_d  = 1'b1;
            end else if (last && op_q == ADD) begin
                ovf_d   = add_cout;
                res_d   = (add_cout && !WRAP_OVF) ? {NDIG{4'd9}} : work_upd;
                state_d = SHOW;
                done_d  = 1'b1;
            end else if (last && add_cout) begin
                res_d   = work_upd;
                state_d = SHOW;
                done_d  = 1'b1;
            end else if (last) begin
                idx_d   = '0;
                carry_d = 1'b1;
                state_d = NEG;
            end
        end else if (key_valid) begin
            if (key_code == K_CLR) begin
                state_d = ENTRY_A;
                op_d    = ADD;
                cur_d   = '0;
                cnt_d   = '0;
                opa_d   = '0;
                opb_d   = '0;
                work_d  = '0;
                res_d   = '0;
                idx_d   = '0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                neg_d   = 1'b0;
                ack_d   = 1'b1;
            end else if (key_code <= 4'd9 && state_q == SHOW) begin
                cur_d   = W'(key_code);
                cnt_d   = CW'(1);
                ovf_d   = 1'b0;
                neg_d   = 1'b0;
                state_d = ENTRY_A;
                ack_d   = 1'b1;
            end else if (key_code <= 4'd9 && cnt_q != CW'(NDIG)) begin
                cur_d = {cur_q[W-5:0], key_code};
                cnt_d = cnt_q + 1'b1;
                ack_d = 1'b1;
            end else if ((key_code == K_ADD || key_code == K_SUB) && !(state_q == SHOW && neg_q)) begin
                op_d  = (key_code == K_SUB) ? SUB : ADD;
                ack_d = 1'b1;
                if (state_q != ENTRY_B) begin
                    opa_d   = (state_q == SHOW) ? res_q : cur_q;
                    cur_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ENTRY_B;
                end
            end else if (key_code == K_EQ && state_q == ENTRY_B) begin
                opb_d   = (op_q == SUB) ? cur_nines : cur_q;
                idx_d   = '0;
                carry_d = op_q == SUB;
                state_d = CALC;
                ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= ADD;
            cur_q   <= '0;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        busy     = state_q == CALC || state_q == NEG;
        key_ack  = ack_q;
        done     = done_q;
        disp_bcd = (state_q == ENTRY_A || state_q == ENTRY_B) ? cur_q : res_q;
        disp_neg = state_q == SHOW && neg_q;
        ovf      = state_q == SHOW && ovf_q;
    end
endmodule
